// File: rtl/dac_pkg.sv
// Shared state encoding and code-conversion helpers for the DAC sample interpolator.
package dac_pkg;

  localparam int DEF_DATA_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    UNDERFLOW
  } state_t;

  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

  // Offset binary is the two's-complement pattern with its sign bit inverted;
  // callers size-cast the result down to their code width.
  function automatic logic [31:0] to_offset_binary(input logic [31:0] value, input int width);
    return value ^ midscale(width);
  endfunction

endpackage

// File: rtl/dac_sample_fifo.sv
// Sample buffer ahead of the interpolator: combinational read of the head entry, level count, synchronous flush.
// Latency: a pushed entry is visible at rdata the cycle after the push; full blocks further pushes until a pop.
module dac_sample_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (do_push && !do_pop)      level <= level + (DEPTH_LOG2 + 1)'(1);
      else if (!do_push && do_pop) level <= level - (DEPTH_LOG2 + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dac_sample_interpolator.sv
// Linear 2**LOG2_RATIO interpolator feeding the DAC encoder; defining DAC_INTERP_DITHER_EN adds +/-1 LSB LFSR dither.
// Latency: dac_code_o is registered one cycle after phase/prev/next; sample_ready_o drops only when the FIFO is full.
module dac_sample_interpolator
  import dac_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LOG2_RATIO      = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enable_i,
  input  logic [DATA_WIDTH-1:0]      sample_i,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  output logic [DATA_WIDTH-1:0]      dac_code_o,
  output logic                       dac_valid_o,
  output logic                       underflow_o,
  input  logic                       underflow_clr_i,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level_o
);

  localparam int                    PW         = (LOG2_RATIO > 0) ? LOG2_RATIO : 1;
  localparam logic [PW-1:0]         PHASE_LAST = PW'((1 << LOG2_RATIO) - 1);
  localparam logic [DATA_WIDTH-1:0] MID        = DATA_WIDTH'(midscale(DATA_WIDTH));

  state_t                        state, state_d;
  logic [PW-1:0]                 phase, phase_d;
  logic signed [DATA_WIDTH-1:0]  smp_prev, smp_prev_d;
  logic signed [DATA_WIDTH-1:0]  smp_next, smp_next_d;
  logic [DATA_WIDTH-1:0]         code, code_d;
  logic                          valid, valid_d;
  logic                          underflow, uf_set;
  logic                          pop;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [DATA_WIDTH-1:0]         fifo_rdata;
  logic [FIFO_DEPTH_LOG2:0]      fifo_level;

  logic signed [DATA_WIDTH:0]         diff;
  logic signed [DATA_WIDTH+PW+1:0]    prod;
  logic signed [DATA_WIDTH-1:0]       interp;
  logic signed [DATA_WIDTH-1:0]       run_val;

  dac_sample_fifo #(
    .WIDTH      (DATA_WIDTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (!enable_i),
    .push   (sample_valid_i),
    .wdata  (sample_i),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // prev + floor((next - prev) * phase / R); the result stays between prev and next,
  // so truncating the shifted product back to DATA_WIDTH before the add is exact.
  always_comb begin
    diff   = (DATA_WIDTH + 1)'(smp_next) - (DATA_WIDTH + 1)'(smp_prev);
    prod   = (DATA_WIDTH + PW + 2)'(diff) * (DATA_WIDTH + PW + 2)'($signed({1'b0, phase}));
    interp = DATA_WIDTH'(prod >>> LOG2_RATIO) + smp_prev;
  end

`ifdef DAC_INTERP_DITHER_EN
  localparam logic signed [DATA_WIDTH+1:0] SAT_MAX  = (DATA_WIDTH + 2)'(midscale(DATA_WIDTH) - 32'd1);
  localparam logic signed [DATA_WIDTH+1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic signed [DATA_WIDTH+1:0] DITH_ONE = (DATA_WIDTH + 2)'(1);

  logic [14:0]                   lfsr;
  logic signed [DATA_WIDTH+1:0]  dith_sum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= 15'h1;
    else         lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  end

  always_comb begin
    dith_sum = (DATA_WIDTH + 2)'(interp);
    unique case (lfsr[1:0])
      2'b00:   dith_sum = dith_sum - DITH_ONE;
      2'b01:   dith_sum = dith_sum + DITH_ONE;
      default: ;
    endcase
    if (dith_sum > SAT_MAX)      run_val = DATA_WIDTH'(SAT_MAX);
    else if (dith_sum < SAT_MIN) run_val = DATA_WIDTH'(SAT_MIN);
    else                         run_val = DATA_WIDTH'(dith_sum);
  end
`else
  assign run_val = interp;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    smp_prev_d = smp_prev;
    smp_next_d = smp_next;
    code_d     = MID;
    valid_d    = 1'b0;
    pop        = 1'b0;
    uf_set     = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      phase_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_level > (FIFO_DEPTH_LOG2 + 1)'(1)) begin
            pop        = 1'b1;
            smp_prev_d = fifo_rdata;
            state_d    = PRIME;
          end
        end
        PRIME: begin
          pop        = 1'b1;
          smp_next_d = fifo_rdata;
          phase_d    = '0;
          state_d    = RUN;
        end
        RUN: begin
          code_d  = DATA_WIDTH'(to_offset_binary(32'(run_val), DATA_WIDTH));
          valid_d = 1'b1;
          if (phase == PHASE_LAST) begin
            smp_prev_d = smp_next;
            if (!fifo_empty) begin
              pop        = 1'b1;
              smp_next_d = fifo_rdata;
              phase_d    = '0;
            end else begin
              uf_set  = 1'b1;
              state_d = UNDERFLOW;
            end
          end else begin
            phase_d = phase + PW'(1);
          end
        end
        UNDERFLOW: begin
          code_d  = DATA_WIDTH'(to_offset_binary(32'(smp_next), DATA_WIDTH));
          valid_d = 1'b1;
          if (!fifo_empty) begin
            pop        = 1'b1;
            smp_next_d = fifo_rdata;
            phase_d    = '0;
            state_d    = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase     <= '0;
      smp_prev  <= '0;
      smp_next  <= '0;
      code      <= MID;
      valid     <= 1'b0;
      underflow <= 1'b0;
    end else begin
      phase     <= phase_d;
      smp_prev  <= smp_prev_d;
      smp_next  <= smp_next_d;
      code      <= code_d;
      valid     <= valid_d;
      // A new underflow event beats a simultaneous clear.
      underflow <= uf_set | (underflow & ~underflow_clr_i);
    end
  end

  assign sample_ready_o = !fifo_full;
  assign dac_code_o     = code;
  assign dac_valid_o    = valid;
  assign underflow_o    = underflow;
  assign fifo_level_o   = fifo_level;

endmodule

// File: tb/tb_dac_sample_interpolator.sv
// Randomised and directed bench for dac_sample_interpolator against a stream-level interpolation model.
module tb_dac_sample_interpolator;

  localparam int DW     = 10;
  localparam int L2R    = 2;
  localparam int R      = 1 << L2R;
  localparam int FDL    = 2;
  localparam int FDEPTH = 1 << FDL;
  localparam int MID    = 1 << (DW - 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           enable;
  logic [DW-1:0]  sample;
  logic           sample_valid;
  logic           sample_ready;
  logic [DW-1:0]  dac_code;
  logic           dac_valid;
  logic           underflow;
  logic           underflow_clr;
  logic [FDL:0]   fifo_level;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  act_q[$];
  int  stim[$];
  bit  collect  = 1'b0;
  int  max_level = 0;

  always #5 clk = ~clk;

  dac_sample_interpolator #(
    .DATA_WIDTH      (DW),
    .LOG2_RATIO      (L2R),
    .FIFO_DEPTH_LOG2 (FDL)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .sample_i        (sample),
    .sample_valid_i  (sample_valid),
    .sample_ready_o  (sample_ready),
    .dac_code_o      (dac_code),
    .dac_valid_o     (dac_valid),
    .underflow_o     (underflow),
    .underflow_clr_i (underflow_clr),
    .fifo_level_o    (fifo_level)
  );

  always @(negedge clk) begin
    if (collect && dac_valid) act_q.push_back(int'(dac_code));
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: value p + floor((n-p)*k/R), then shifted into offset-binary range.
  function automatic int exp_code(input int p, input int n, input int k);
    int num;
    int q;
    num = (n - p) * k;
    q   = num / R;
    if ((num % R) != 0 && num < 0) q = q - 1;
    return p + q + MID;
  endfunction

  task automatic push_all();
    int i;
    int guard;
    bit ok;
    i = 0;
    guard = 0;
    while (i < stim.size() && guard < 500) begin
      sample       = DW'(stim[i]);
      sample_valid = 1'b1;
      ok           = sample_ready;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      check_eq("ready_vs_level", int'(sample_ready), int'(int'(fifo_level) < FDEPTH));
      @(negedge clk);
      guard++;
      if (ok) i++;
    end
    sample_valid = 1'b0;
    check_eq("push_done", i, stim.size());
  endtask

  task automatic run_stream(input bit hold_clr);
    int n;
    int guard;
    int idx;
    n = stim.size();
    act_q.delete();
    collect       = 1'b1;
    underflow_clr = hold_clr;
    enable        = 1'b1;
    push_all();
    guard = 0;
    while (!underflow && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq("underflow_set", int'(underflow), 1);
    if (hold_clr) begin
      @(negedge clk);
      check_eq("clr_after_set", int'(underflow), 0);
      underflow_clr = 1'b0;
    end
    repeat (3) @(negedge clk);
    collect = 1'b0;
    check_eq("stream_len", int'(act_q.size() > (n - 1) * R), 1);
    for (int s = 0; s < n - 1; s++) begin
      for (int k = 0; k < R; k++) begin
        idx = s * R + k;
        if (idx < act_q.size())
          check_eq($sformatf("stream[%0d]", idx), act_q[idx], exp_code(stim[s], stim[s+1], k));
      end
    end
    check_eq("hold_code", int'(dac_code), exp_code(stim[n-1], stim[n-1], 0));
    check_eq("hold_valid", int'(dac_valid), 1);
  endtask

  task automatic clear_flag();
    underflow_clr = 1'b1;
    @(negedge clk);
    underflow_clr = 1'b0;
    check_eq("uf_cleared", int'(underflow), 0);
  endtask

  task automatic end_scenario();
    clear_flag();
    enable = 1'b0;
    @(negedge clk);
    check_eq("idle_code", int'(dac_code), MID);
    check_eq("idle_valid", int'(dac_valid), 0);
    check_eq("idle_level", int'(fifo_level), 0);
  endtask

  task automatic wait_valid(input string tag);
    int guard;
    guard = 0;
    while (!dac_valid && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, int'(dac_valid), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int j;
    rst_n         = 1'b0;
    enable        = 1'b0;
    sample        = '0;
    sample_valid  = 1'b0;
    underflow_clr = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_code", int'(dac_code), MID);
    check_eq("rst_valid", int'(dac_valid), 0);
    check_eq("rst_underflow", int'(underflow), 0);
    check_eq("rst_level", int'(fifo_level), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", int'(sample_ready), 1);

    stim = {0, 100, 100};
    run_stream(1'b0);
    end_scenario();

    // Clear held high across the underflow event: the set must still be seen for one cycle.
    stim = {0, -3};
    run_stream(1'b1);
    end_scenario();

    stim = {-512, 511};
    run_stream(1'b0);
    end_scenario();

    stim = {20, -8, 40};
    run_stream(1'b0);
    clear_flag();
    act_q.delete();
    collect = 1'b1;
    stim = {-60};
    push_all();
    repeat (12) @(negedge clk);
    collect = 1'b0;
    j = 0;
    while (j < act_q.size() && act_q[j] == exp_code(40, 40, 0)) j++;
    for (int k = 1; k < R; k++) begin
      check_eq($sformatf("resume_k%0d", k),
               (j + k - 1 < act_q.size()) ? act_q[j+k-1] : -1, exp_code(40, -60, k));
    end
    check_eq("resume_uf", int'(underflow), 1);
    check_eq("resume_hold", int'(dac_code), exp_code(-60, -60, 0));
    end_scenario();

    stim.delete();
    for (int i = 0; i < 20; i++) stim.push_back(int'($urandom_range(0, 1023)) - 512);
    max_level = 0;
    run_stream(1'b0);
    check_eq("fifo_filled", max_level, FDEPTH);
    end_scenario();

    stim = {300, -300, 200, 100};
    enable = 1'b1;
    push_all();
    wait_valid("dis_run_started");
    check_eq("dis_level_busy", int'(fifo_level > 0), 1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("dis_code", int'(dac_code), MID);
    check_eq("dis_valid", int'(dac_valid), 0);
    check_eq("dis_level", int'(fifo_level), 0);
    check_eq("dis_ready", int'(sample_ready), 1);
    check_eq("dis_uf", int'(underflow), 0);

    stim = {100, 200, 300, -100};
    enable = 1'b1;
    push_all();
    wait_valid("rst_run_started");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_code", int'(dac_code), MID);
    check_eq("arst_valid", int'(dac_valid), 0);
    check_eq("arst_level", int'(fifo_level), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst_ready", int'(sample_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
